// File: rtl/sort_three_floats_seq.sv
// rtl/sort_three_floats_seq.sv - sequential 3-element float sorter with one shared comparator
// f_less_or_equal flags NaN/infinity on err; res is meaningless when err is set.

module f_less_or_equal #(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);
  localparam int EW = (FLEN == 32) ? 8 : 11;

  logic            sa, sb, a_special, b_special, both_zero;
  logic [FLEN-2:0] a_mag, b_mag;

  always_comb begin
    sa        = a[FLEN-1];
    sb        = b[FLEN-1];
    a_mag     = a[FLEN-2:0];
    b_mag     = b[FLEN-2:0];
    a_special = &a[FLEN-2 -: EW];
    b_special = &b[FLEN-2 -: EW];
    both_zero = (a_mag == '0) && (b_mag == '0);
    err       = a_special | b_special;
    res       = 1'b1;
    // Sign-magnitude ordering; negative magnitudes compare in reverse.
    if (both_zero)   res = 1'b1;
    else if (sa != sb) res = sa;
    else if (sa)     res = (a_mag >= b_mag);
    else             res = (a_mag <= b_mag);
  end
endmodule

module sort_three_floats_seq #(
  parameter int FLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [2:0][FLEN-1:0] unsorted,
  output logic                 ready_out,
  output logic                 valid_out,
  output logic [2:0][FLEN-1:0] sorted,
  output logic                 err
);
  typedef enum logic [2:0] {IDLE, CMP01, CMP12, CMP01B, DONE} state_t;

  state_t          state;
  logic [FLEN-1:0] r0, r1, r2;
  logic            err_acc;
  logic [FLEN-1:0] cmp_a, cmp_b, lo, hi;
  logic            cmp_res, cmp_err, do_swap;

  assign ready_out = (state == IDLE);

  // Operand mux: only CMP12 looks at the upper pair.
  always_comb begin
    cmp_a   = (state == CMP12) ? r1 : r0;
    cmp_b   = (state == CMP12) ? r2 : r1;
    do_swap = !cmp_res && !cmp_err;
    lo      = do_swap ? cmp_b : cmp_a;
    hi      = do_swap ? cmp_a : cmp_b;
  end

  f_less_or_equal #(.FLEN(FLEN)) u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      err_acc   <= 1'b0;
      sorted    <= '0;
      err       <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            r0      <= unsorted[0];
            r1      <= unsorted[1];
            r2      <= unsorted[2];
            err_acc <= 1'b0;
            state   <= CMP01;
          end
        end
        CMP01: begin
          r0      <= lo;
          r1      <= hi;
          err_acc <= err_acc | cmp_err;
          state   <= CMP12;
        end
        CMP12: begin
          r1      <= lo;
          r2      <= hi;
          err_acc <= err_acc | cmp_err;
          state   <= CMP01B;
        end
        CMP01B: begin
          // Final pass publishes the result directly so it is visible in DONE.
          r0        <= lo;
          r1        <= hi;
          err_acc   <= err_acc | cmp_err;
          sorted    <= {r2, hi, lo};
          err       <= err_acc | cmp_err;
          valid_out <= 1'b1;
          state     <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
